// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the framed UART receiver
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_COMMIT    = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

  function automatic int bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// rtl/uart_rx_framed_if.sv - received-word handshake between receiver and consumer
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rxd synchroniser, bit-cell tick counter and 3-sample majority voter
module uart_rx_sampler #(
  parameter int BIT_TICKS   = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rxd_i,
  input  logic clr_i,
  output logic rxs_o,
  output logic fall_o,
  output logic sample_strobe_o,
  output logic sample_bit_o
);

  localparam int HALF = BIT_TICKS / 2;
  localparam int TW   = $clog2(BIT_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic                   vote_a_q, vote_b_q;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    tick_d = tick_q + TW'(1);
    if (clr_i || tick_q == TW'(BIT_TICKS - 1)) begin
      tick_d = '0;
    end
  end

  // Synchroniser loads idle-high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
      tick_q     <= '0;
      vote_a_q   <= 1'b1;
      vote_b_q   <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd_i};
      rxs_prev_q <= rxs;
      tick_q     <= tick_d;
      if (tick_q == TW'(HALF - 1)) vote_a_q <= rxs;
      if (tick_q == TW'(HALF))     vote_b_q <= rxs;
    end
  end

  assign rxs_o           = rxs;
  assign fall_o          = rxs_prev_q & ~rxs;
  assign sample_strobe_o = (tick_q == TW'(HALF + 1));
  assign sample_bit_o    = (vote_a_q & vote_b_q) | (vote_a_q & rxs) | (vote_b_q & rxs);

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - UART receiver with parity/framing checks and valid/ready output
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 230400,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  output logic             busy,
  uart_rx_framed_if.master rx
);

  localparam int      BIT_TICKS = bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam int      BW        = $clog2(DATA_BITS + 1);
  localparam parity_e PAR_MODE  = parity_e'(PARITY);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_framed: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_framed: STOP_BITS must be 1..2");
  end
  if (BIT_TICKS < 8) begin : g_bad_bit_ticks
    $error("uart_rx_framed: BIT_TICKS must be at least 8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_framed: SYNC_STAGES must be at least 2");
  end

  logic rxs, fall, strobe, sbit, tick_clr, commit;

  uart_rx_sampler #(
    .BIT_TICKS  (BIT_TICKS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk            (clk),
    .reset          (reset),
    .rxd_i          (rxd),
    .clr_i          (tick_clr),
    .rxs_o          (rxs),
    .fall_o         (fall),
    .sample_strobe_o(strobe),
    .sample_bit_o   (sbit)
  );

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 par_calc;

  assign par_calc = ^{shift_q, sbit};

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall) state_d = ST_START;
      ST_START:  if (strobe) state_d = sbit ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (strobe && bit_cnt_q == BW'(DATA_BITS - 1)) begin
          state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      ST_PARITY: if (strobe) state_d = ST_STOP;
      ST_STOP:   if (strobe && bit_cnt_q == BW'(STOP_BITS - 1)) state_d = ST_COMMIT;
      // A low stop bit may be a break; hold off re-arming until the line is high.
      ST_COMMIT: state_d = ferr_acc_q ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (rxs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    tick_clr = (state_q == ST_IDLE) && fall;
    commit   = (state_q == ST_COMMIT);
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    case (state_q)
      ST_START: begin
        bit_cnt_d  = '0;
        perr_acc_d = 1'b0;
        ferr_acc_d = 1'b0;
      end
      ST_DATA:
        if (strobe) begin
          shift_d   = {sbit, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = (bit_cnt_q == BW'(DATA_BITS - 1)) ? '0 : bit_cnt_q + BW'(1);
        end
      ST_PARITY:
        if (strobe) perr_acc_d = (PAR_MODE == PAR_ODD) ? ~par_calc : par_calc;
      ST_STOP:
        if (strobe) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (!sbit) ferr_acc_d = 1'b1;
        end
      default: ;
    endcase
  end

  // A commit against an unaccepted word drops the new frame and flags overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (commit) begin
      if (!valid_q || rx.rx_ready) begin
        data_d  = shift_q;
        perr_d  = perr_acc_q;
        ferr_d  = ferr_acc_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed bench for uart_rx_framed (8N1 and 8E1 instances)
module tb_uart_rx_framed;

  localparam int BIT = 434;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd0 = 1'b1;
  logic rxd1 = 1'b1;
  logic busy0, busy1;

  int errors = 0;
  int checks = 0;
  int acc0 = 0, acc1 = 0, ov0 = 0;
  logic [7:0] last0 = '0, last1 = '0;
  logic lperr0 = 1'b0, lferr0 = 1'b0, lperr1 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_framed_if #(.DATA_BITS(8)) if0 ();
  uart_rx_framed_if #(.DATA_BITS(8)) if1 ();

  uart_rx_framed u0 (
    .clk  (clk),
    .reset(reset),
    .rxd  (rxd0),
    .busy (busy0),
    .rx   (if0)
  );

  uart_rx_framed #(.PARITY(2)) u1 (
    .clk  (clk),
    .reset(reset),
    .rxd  (rxd1),
    .busy (busy1),
    .rx   (if1)
  );

  always @(negedge clk) begin
    if (if0.rx_valid && if0.rx_ready) begin
      acc0++;
      last0  = if0.rx_data;
      lperr0 = if0.parity_err;
      lferr0 = if0.frame_err;
    end
    if (if1.rx_valid && if1.rx_ready) begin
      acc1++;
      last1  = if1.rx_data;
      lperr1 = if1.parity_err;
    end
    if (if0.overrun) ov0++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd1 = v;
    else     rxd0 = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                      input logic pbit, input logic stopv);
    @(negedge clk);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (has_par) drive(sel, pbit);
    drive(sel, stopv);
    if (sel) rxd1 = 1'b1;
    else     rxd0 = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    if0.rx_ready = 1'b1;
    if1.rx_ready = 1'b1;
    settle(5);
    reset = 1'b0;
    settle(2);
    check("rst_valid", 32'(if0.rx_valid), 32'd0);
    check("rst_data", 32'(if0.rx_data), 32'h00);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_flags", 32'({if0.parity_err, if0.frame_err, if0.overrun}), 32'd0);
    check("rst_valid_par", 32'(if1.rx_valid), 32'd0);

    // 1: 0xA5 8N1
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    settle(4);
    check("t1_count", 32'(acc0), 32'd1);
    check("t1_data", 32'(last0), 32'h0A5);
    check("t1_flags", 32'({lperr0, lferr0}), 32'd0);
    check("t1_valid_drop", 32'(if0.rx_valid), 32'd0);
    check("t1_busy", 32'(busy0), 32'd0);

    // 2: even parity, 0x3C has four ones
    send(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    settle(4);
    check("t2_data_bad", 32'(last1), 32'h03C);
    check("t2_perr_bad", 32'(lperr1), 32'd1);
    send(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    settle(4);
    check("t2_perr_good", 32'(lperr1), 32'd0);
    check("t2_count", 32'(acc1), 32'd2);

    // 3: framing error, break, recovery
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    rxd0 = 1'b0;
    check("t3_data", 32'(last0), 32'h055);
    check("t3_ferr", 32'(lferr0), 32'd1);
    repeat (20 * BIT) @(negedge clk);
    settle(1);
    check("t3_break_busy", 32'(busy0), 32'd1);
    check("t3_break_count", 32'(acc0), 32'd2);
    rxd0 = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    settle(1);
    check("t3_idle_busy", 32'(busy0), 32'd0);
    send(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    settle(4);
    check("t3_rec_count", 32'(acc0), 32'd3);
    check("t3_rec_data", 32'(last0), 32'h00F);
    check("t3_rec_ferr", 32'(lferr0), 32'd0);

    // 4: overrun
    if0.rx_ready = 1'b0;
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    settle(4);
    check("t4_valid", 32'(if0.rx_valid), 32'd1);
    check("t4_held1", 32'(if0.rx_data), 32'h011);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    settle(4);
    check("t4_held2", 32'(if0.rx_data), 32'h011);
    check("t4_overrun_cycles", 32'(ov0), 32'd1);
    @(posedge clk);
    #1 if0.rx_ready = 1'b1;
    settle(2);
    check("t4_accept_count", 32'(acc0), 32'd4);
    check("t4_accept_data", 32'(last0), 32'h011);
    check("t4_valid_drop", 32'(if0.rx_valid), 32'd0);

    // 5: 100-cycle glitch
    @(negedge clk);
    rxd0 = 1'b0;
    repeat (100) @(negedge clk);
    rxd0 = 1'b1;
    settle(1);
    check("t5_busy_start", 32'(busy0), 32'd1);
    repeat (BIT) @(negedge clk);
    settle(1);
    check("t5_busy_done", 32'(busy0), 32'd0);
    check("t5_count", 32'(acc0), 32'd4);
    check("t5_valid", 32'(if0.rx_valid), 32'd0);

    // 6: reset mid-DATA of 0xFF
    @(negedge clk);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    check("t6_busy_mid", 32'(busy0), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    settle(1);
    check("t6_busy_rst", 32'(busy0), 32'd0);
    repeat (2 * BIT) @(negedge clk);
    send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    settle(4);
    check("t6_count", 32'(acc0), 32'd5);
    check("t6_data", 32'(last0), 32'h081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
